// File: rtl/iiitb_rtc_uart_tx_if.sv
// iiitb_rtc_uart_tx_if: RTC digit bus, report enable and UART status between RTC and transmitter
interface iiitb_rtc_uart_tx_if;
  logic en;
  logic [3:0] hrm, hrl, minm, minl, secm, secl;
  logic txd, busy, frame_done, overrun;
  modport master (
    output en, hrm, hrl, minm, minl, secm, secl,
    input txd, busy, frame_done, overrun
  );
  modport slave (
    input en, hrm, hrl, minm, minl, secm, secl,
    output txd, busy, frame_done, overrun
  );
endinterface

// File: rtl/iiitb_rtc_uart_tx.sv
// iiitb_rtc_uart_tx: sends the RTC time as "HH:MM:SS" over an 8N1 UART whenever a digit changes.
// Defining IIITB_RTC_TX_CRLF_EN appends CR LF to every frame.
module iiitb_rtc_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic clkin,
  input logic rst,
  iiitb_rtc_uart_tx_if.slave bus
);
  localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef IIITB_RTC_TX_CRLF_EN
  localparam logic [3:0] LAST = 4'd9;
`else
  localparam logic [3:0] LAST = 4'd7;
`endif
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0] bitc, bitc_d;
  logic [3:0] idx, idx_d;
  logic [23:0] digits, prev, snap, snap_d;
  logic pending, pending_d, change, start, baud_end;
  logic [7:0] chr;
  function automatic logic [7:0] enc(input logic [3:0] d);
    return d < 4'd10 ? {4'h3, d} : 8'h3F;
  endfunction
  assign digits = {bus.hrm, bus.hrl, bus.minm, bus.minl, bus.secm, bus.secl};
  assign change = digits != prev;
  assign baud_end = baud == BW'(CLKS_PER_BIT - 1);
  assign start = state == IDLE && bus.en && (change || pending);
  assign bus.busy = state != IDLE;
  assign bus.overrun = change && bus.busy;
  assign bus.frame_done = state == STOP && baud_end && idx == LAST;
  assign bus.txd = state == DATA ? chr[bitc] : state != START;
  // a change seen while a frame is running or reports are disabled is remembered
  assign pending_d = start ? 1'b0 : pending | (change & (bus.busy | ~bus.en));
  always_comb begin
    chr = 8'h3A;
    case (idx)
      4'd0: chr = enc(snap[23:20]);
      4'd1: chr = enc(snap[19:16]);
      4'd3: chr = enc(snap[15:12]);
      4'd4: chr = enc(snap[11:8]);
      4'd6: chr = enc(snap[7:4]);
      4'd7: chr = enc(snap[3:0]);
`ifdef IIITB_RTC_TX_CRLF_EN
      4'd8: chr = 8'h0D;
      4'd9: chr = 8'h0A;
`endif
      default: chr = 8'h3A;
    endcase
  end
  always_comb begin
    state_d = state;
    bitc_d = bitc;
    idx_d = idx;
    snap_d = snap;
    baud_d = (state == IDLE || baud_end) ? '0 : baud + BW'(1);
    case (state)
      IDLE: if (start) begin
        state_d = START;
        snap_d = digits;
        idx_d = 4'd0;
      end
      START: if (baud_end) begin
        state_d = DATA;
        bitc_d = 3'd0;
      end
      DATA: if (baud_end) begin
        bitc_d = bitc + 3'd1;
        state_d = bitc == 3'd7 ? STOP : DATA;
      end
      STOP: if (baud_end) begin
        state_d = idx == LAST ? IDLE : START;
        idx_d = idx == LAST ? idx : idx + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      baud <= '0;
      bitc <= 3'd0;
      idx <= 4'd0;
      snap <= 24'd0;
      prev <= 24'd0;
      pending <= 1'b0;
    end else begin
      state <= state_d;
      baud <= baud_d;
      bitc <= bitc_d;
      idx <= idx_d;
      snap <= snap_d;
      prev <= digits;
      pending <= pending_d;
    end
  end
endmodule

// File: doc/iiitb_rtc_uart_tx.md
# iiitb_rtc_uart_tx

Serial time-report transmitter for the RTC. Watches the six BCD time digits produced by the RTC counter chain and, whenever any digit changes, sends the current time as an ASCII string "HH:MM:SS" over an 8N1 UART line. It sits beside the RTC, on the same clock, and converts the parallel digit outputs into a byte stream for a host terminal.

## Interface
- `CLKS_PER_BIT`, default 16: clkin cycles per UART bit. Legal range is ≥2.
- `clkin`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  report enable. While low, no new frame starts. A frame already in progress completes.
- `hrm, hrl, minm, minl, secm, secl`  in  4 each  BCD time digits from the RTC.
- `txd`  out  1  UART serial output. Idle high, LSB first.
- `busy`  out  1  high from the first start-bit cycle through the last stop-bit cycle of a frame.
- `frame_done`  out  1  one-cycle pulse in the final cycle of the last stop bit.
- `overrun`  out  1  one-cycle pulse when a digit change is detected while `busy` is high.

## Operation
- **Change detect.** A 24-bit `prev` register copies the digit bus every cycle.
  - `change` = (digit bus != `prev`).
  - `prev` resets to 0, matching the RTC reset state.
- **Pending flag.** Set by `change` while busy or while `en`=0. Cleared when a frame starts.
  - A change that occurs while `en`=0 leaves `pending` set. The frame then starts when `en` rises.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when `en`=1 and (`change` or `pending`). In that cycle the whole digit bus is captured into a snapshot register, and the character index is set to 0.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then → DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then → STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles. Then:
    - → START with the next character index, if characters remain;
    - otherwise → IDLE, pulsing `frame_done`.
- **Character sequence (index 0..7):** hrm, hrl, ':', minm, minl, ':', secm, secl.
- **Digit encoding.** A digit d of 0..9 is sent as 8'h30+d. Digit values 10..15 are sent as 8'h3F ('?').
  - ':' is 8'h3A.
- **Snapshot rule.** The snapshot is stable for the whole frame. Digit changes during a frame never alter bytes already queued.
- **Counters.**
  - Baud counter: 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Bit counter: 3 bits.
  - Character index: 4 bits.
- **Reset** (asynchronous, any state, including mid-frame):
  - `txd`=1, `busy`=0, `frame_done`=0, `overrun`=0.
  - FSM returns to IDLE; `pending`=0; `prev`=0; snapshot=0.

## Timing
- **Start latency.** If `change` is detected in cycle N (FSM in IDLE, `en`=1), the start bit begins in cycle N+1 (`txd` low, `busy` high).
- **Frame length** is 8×10×CLKS_PER_BIT cycles. `frame_done` is high in the last of these.
- **Back-to-back frames.**
  - After `frame_done` the FSM spends at least one IDLE cycle with `txd`=1.
  - If `pending` is set, that IDLE cycle captures the digits present then, and the start bit follows in the next cycle.
- **Simultaneous events.** Reset dominates everything. A change in the same cycle as `frame_done` counts as busy: `overrun` pulses and `pending` is set.
- **Overrun.** `overrun` pulses once per cycle in which `change`=1 and `busy`=1.

## Configuration
- **`IIITB_RTC_TX_CRLF_EN`**
  - Defined: each frame appends CR (8'h0D) and LF (8'h0A) as indices 8 and 9. The frame is 10 characters, or 100×CLKS_PER_BIT cycles.
  - Undefined: the frame ends after secl. It is 8 characters, or 80×CLKS_PER_BIT cycles, and the CR/LF logic is absent.

## Test plan
- **Basic frame.** CLKS_PER_BIT=4, `en`=1, digits step from all 0 to 1,2,3,4,5,6.
  - Decoded bytes are 31 32 3A 33 34 3A 35 36.
  - `busy` is high for 320 cycles starting the cycle after the change, and `frame_done` pulses in the last of them.
- **Overrun.** Change the digits again 50 cycles into a frame.
  - `overrun` pulses once.
  - The current frame is unaltered.
  - After `frame_done` and one idle cycle, a second frame carries the new digits.
- **Invalid digit.** Set secl=4'hA. The final byte is 3F.
- **Enable gating.** With `en`=0, change the digits: `txd` stays 1 and `busy` stays 0. Raising `en` starts a frame in the next cycle with the current digits.
- **Mid-frame reset.** Assert `rst`=0 during a DATA bit.
  - `txd`=1 and `busy`=0 immediately, without waiting for a clock edge.
  - After release with no digit change, no frame is sent.
- **CRLF option.** With `IIITB_RTC_TX_CRLF_EN` defined, the frame is 10 bytes ending 0D 0A, and lasts 400 cycles at CLKS_PER_BIT=4.
